multicycle_uc: RTL and testbench
================================

# multicycle_uc

Main control FSM for the multicycle RV32I-subset datapath. It sequences instruction fetch, decode, execute, memory access and write-back. It drives the datapath mux selects, the register and memory strobes, and the 2-bit `aluOp` consumed by the ALU control unit. It also takes that unit's `branch` result to resolve conditional branches, and stalls on a simple memory ready handshake.

## Interface
Parameters:
- `OPC_R`, default 7'b0110011, opcode of R-type ALU instructions
- `OPC_I`, default 7'b0010011, opcode of I-type ALU instructions
- `OPC_LD`, default 7'b0000011, opcode of loads
- `OPC_ST`, default 7'b0100011, opcode of stores
- `OPC_BR`, default 7'b1100011, opcode of branches

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 7: IR[6:0], valid from DECODE onward.
- `branch` in 1: branch-taken result from the ALU control unit.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR and OldPC.
- `pc_write` out 1: load PC.
- `pc_src` out 1: PC source; 0 = ALU result, 1 = ALUOut.
- `alu_src_a` out 2: 00 = PC, 01 = OldPC, 10 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = constant 4, 10 = immediate.
- `aluOp` out 2: 00 = add, 01 = I-type, 10 = R-type.
- `reg_write` out 1: register file write.
- `mem_to_reg` out 1: write-back source; 0 = ALUOut, 1 = MDR.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `instr_count` out 32: count of instructions fetched.
- `state` out 4: current state, for debug.

## Operation
- States: FETCH, DECODE, ADDR, MEM_RD, MEM_WR, WB_MEM, EXEC_R, EXEC_I, WB_ALU, BRANCH.
- Outputs are decoded from the state. Any strobe not listed for a state is 0; any select not listed is 00 or 0.
- FETCH:
  - Asserts `mem_read`, with `iord`=0.
  - Holds until `mem_ready`=1.
  - In the `mem_ready` cycle only, also asserts `ir_write` and `pc_write`, with `alu_src_a`=00, `alu_src_b`=01, `aluOp`=00 and `pc_src`=0, so that PC <= PC+4.
  - On that cycle, `instr_count` increments (wraps 0xFFFFFFFF -> 0) and the FSM goes to DECODE.
- DECODE:
  - Drives `alu_src_a`=01, `alu_src_b`=10, `aluOp`=00, so ALUOut <= OldPC+imm (branch target).
  - Next state by `opcode`: OPC_R -> EXEC_R; OPC_I -> EXEC_I; OPC_LD or OPC_ST -> ADDR; OPC_BR -> BRANCH.
  - Any other opcode: `illegal`=1 for this cycle, next state FETCH.
- ADDR: `alu_src_a`=10, `alu_src_b`=10, `aluOp`=00. Next state is MEM_RD if `opcode`==OPC_LD, else MEM_WR.
- MEM_RD: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then goes to WB_MEM.
- MEM_WR: `mem_write`=1, `iord`=1. Holds until `mem_ready`, then goes to FETCH.
- WB_MEM: `reg_write`=1, `mem_to_reg`=1. Next state FETCH.
- EXEC_R: `alu_src_a`=10, `alu_src_b`=00, `aluOp`=10. Next state WB_ALU.
- EXEC_I: `alu_src_a`=10, `alu_src_b`=10, `aluOp`=01. Next state WB_ALU.
- WB_ALU: `reg_write`=1, `mem_to_reg`=0. Next state FETCH.
- BRANCH:
  - Drives `alu_src_a`=10, `alu_src_b`=00, `aluOp`=00, `pc_src`=1.
  - `pc_write` = `branch`, combinationally.
  - Next state FETCH.
- `mem_read` and `mem_write` are never asserted together.
- `mem_ready` is ignored in every state that is not requesting memory.
- Unused `state` encodings go to FETCH on the next edge.

## Timing
- Reset: a rising edge with `rst_n`=0 sets `state` to FETCH and `instr_count` to 0.
- While `rst_n`=0, every output strobe is forced to 0 combinationally: `mem_read`, `mem_write`, `ir_write`, `pc_write`, `reg_write`, `illegal`. Selects read 0.
- Reset mid-operation, including during a memory wait, aborts the instruction. No write strobe is asserted in the reset cycle.
- Cycles per instruction with `mem_ready` tied to 1:
  - R and I: 4 (FETCH, DECODE, EXEC, WB_ALU).
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Illegal: 2.
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Request signals stay stable throughout the wait.
- `pc_write` in FETCH and BRANCH is a same-cycle function of `mem_ready` and `branch` respectively. All other outputs depend only on `state`.

## Test plan
- Reset and R-type:
  - Stimulus: hold `rst_n`=0 for 2 cycles, release, `mem_ready`=1, `opcode`=0110011.
  - Required: state sequence FETCH, DECODE, EXEC_R, WB_ALU, FETCH.
  - Required: `aluOp`=10 in EXEC_R, `reg_write`=1 only in WB_ALU, `instr_count`=1 after the first FETCH.
- Load with wait states:
  - Stimulus: `opcode`=0000011, `mem_ready` low for 3 cycles in MEM_RD.
  - Required: MEM_RD lasts 4 cycles with `mem_read`=1 and `iord`=1 throughout.
  - Required: WB_MEM asserts `reg_write`=1 and `mem_to_reg`=1; total 8 cycles.
- Store:
  - Stimulus: `opcode`=0100011.
  - Required: `mem_write`=1 only in MEM_WR, `reg_write` never asserted, return to FETCH after 4 cycles.
- Branch:
  - Stimulus: `opcode`=1100011, run once with `branch`=1 and once with `branch`=0.
  - Required: `pc_write`=1 with `pc_src`=1 in BRANCH for the first run; `pc_write`=0 in BRANCH for the second.
- Illegal opcode:
  - Stimulus: `opcode`=1111111.
  - Required: `illegal` pulses for exactly one cycle in DECODE, then FETCH; no `reg_write` or `mem_write`.
- Mid-operation reset:
  - Stimulus: assert `rst_n`=0 during a MEM_WR wait.
  - Required: `mem_write` drops to 0 in the same cycle; `state`=FETCH and `instr_count`=0 after the edge.

Source files
------------

// File: rtl/multicycle_uc.sv
// multicycle_uc: main control FSM for the multicycle RV32I-subset datapath.
// Sequences fetch, decode, execute, memory access and write-back, drives the
// datapath selects/strobes and stalls on the memory ready handshake.
module multicycle_uc #(
  parameter logic [6:0] OPC_R  = 7'b0110011,
  parameter logic [6:0] OPC_I  = 7'b0010011,
  parameter logic [6:0] OPC_LD = 7'b0000011,
  parameter logic [6:0] OPC_ST = 7'b0100011,
  parameter logic [6:0] OPC_BR = 7'b1100011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  aluOp,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [31:0] instr_count,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_MEM = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_WB_ALU = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] count_reg;

  // State register and fetched-instruction counter, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH && mem_ready) begin
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  // Next-state logic; memory states hold until mem_ready, stray encodings recover to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OPC_R)                          state_next = S_EXEC_R;
        else if (opcode == OPC_I)                     state_next = S_EXEC_I;
        else if (opcode == OPC_LD || opcode == OPC_ST) state_next = S_ADDR;
        else if (opcode == OPC_BR)                    state_next = S_BRANCH;
        else                                          state_next = S_FETCH;
      end
      S_ADDR:   state_next = (opcode == OPC_LD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_next = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_MEM: state_next = S_FETCH;
      S_EXEC_R: state_next = S_WB_ALU;
      S_EXEC_I: state_next = S_WB_ALU;
      S_WB_ALU: state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Output decode from state; everything held at 0 while reset is asserted
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    aluOp      = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          illegal   = !(opcode == OPC_R || opcode == OPC_I || opcode == OPC_LD ||
                        opcode == OPC_ST || opcode == OPC_BR);
        end
        S_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          aluOp     = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
          aluOp     = 2'b01;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          pc_src    = 1'b1;
          pc_write  = branch;
        end
        default: begin
        end
      endcase
    end
  end

  assign instr_count = count_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_multicycle_uc.sv
// tb_multicycle_uc: scoreboard bench for the multicycle control FSM.
// The driver walks instructions phase by phase, pushing expected per-cycle
// outputs into a queue; a monitor pops and compares on every falling edge.
module tb_multicycle_uc;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam logic [3:0] P_FETCH  = 4'd0;
  localparam logic [3:0] P_DECODE = 4'd1;
  localparam logic [3:0] P_ADDR   = 4'd2;
  localparam logic [3:0] P_MEM_RD = 4'd3;
  localparam logic [3:0] P_MEM_WR = 4'd4;
  localparam logic [3:0] P_WB_MEM = 4'd5;
  localparam logic [3:0] P_EXEC_R = 4'd6;
  localparam logic [3:0] P_EXEC_I = 4'd7;
  localparam logic [3:0] P_WB_ALU = 4'd8;
  localparam logic [3:0] P_BRANCH = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        branch = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_read, mem_write, iord, ir_write, pc_write, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic        reg_write, mem_to_reg, illegal;
  logic [31:0] instr_count;
  logic [3:0]  state;

  typedef struct {
    bit          inReset;
    logic [3:0]  st;
    logic [14:0] outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cycleNo = 0;
  logic [31:0] modelCount = 32'd0;

  multicycle_uc dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch(branch), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluOp(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit isLegal(input logic [6:0] opc);
    return (opc == OPC_R || opc == OPC_I || opc == OPC_LD || opc == OPC_ST || opc == OPC_BR);
  endfunction

  // Expected control word for one cycle of a phase, straight from the phase table
  function automatic logic [14:0] phaseOuts(input logic [3:0] ph, input logic rdy,
                                            input logic br, input logic ill);
    logic mr, mw, io, irw, pcw, pcs, rw, m2r, il;
    logic [1:0] a, b, op;
    mr = 0; mw = 0; io = 0; irw = 0; pcw = 0; pcs = 0; rw = 0; m2r = 0; il = 0;
    a = 2'b00; b = 2'b00; op = 2'b00;
    case (ph)
      P_FETCH:  begin mr = 1; if (rdy) begin irw = 1; pcw = 1; b = 2'b01; end end
      P_DECODE: begin a = 2'b01; b = 2'b10; il = ill; end
      P_ADDR:   begin a = 2'b10; b = 2'b10; end
      P_MEM_RD: begin mr = 1; io = 1; end
      P_MEM_WR: begin mw = 1; io = 1; end
      P_WB_MEM: begin rw = 1; m2r = 1; end
      P_EXEC_R: begin a = 2'b10; op = 2'b10; end
      P_EXEC_I: begin a = 2'b10; b = 2'b10; op = 2'b01; end
      P_WB_ALU: begin rw = 1; end
      P_BRANCH: begin a = 2'b10; pcs = 1; pcw = br; end
      default:  begin end
    endcase
    return {mr, mw, io, irw, pcw, pcs, a, b, op, rw, m2r, il};
  endfunction

  // Drive one cycle of inputs and record what the DUT must show in that cycle
  task automatic applyStimulus(input logic rs, input logic rdy, input logic br,
                               input logic [6:0] opc, input logic [3:0] ph, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rs;
    mem_ready = rdy;
    branch = br;
    opcode = opc;
    e.inReset = !rs;
    e.st = ph;
    e.cnt = modelCount;
    e.outs = rs ? phaseOuts(ph, rdy, br, ill) : 15'd0;
    sbq.push_back(e);
    if (!rs) modelCount = 32'd0;
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // One instruction: fetch waits fw, memory waits mw, reset during store wait rstAt (-1 = none)
  task automatic runInstr(input logic [6:0] opc, input int fw, input int mw,
                          input logic br, input int rstAt);
    for (int i = 0; i < fw; i++) applyStimulus(1, 0, rbit(), opc, P_FETCH, 0);
    applyStimulus(1, 1, rbit(), opc, P_FETCH, 0);
    modelCount = modelCount + 32'd1;
    applyStimulus(1, rbit(), rbit(), opc, P_DECODE, !isLegal(opc));
    if (opc == OPC_R) begin
      applyStimulus(1, rbit(), rbit(), opc, P_EXEC_R, 0);
      applyStimulus(1, rbit(), rbit(), opc, P_WB_ALU, 0);
    end else if (opc == OPC_I) begin
      applyStimulus(1, rbit(), rbit(), opc, P_EXEC_I, 0);
      applyStimulus(1, rbit(), rbit(), opc, P_WB_ALU, 0);
    end else if (opc == OPC_LD) begin
      applyStimulus(1, rbit(), rbit(), opc, P_ADDR, 0);
      for (int i = 0; i < mw; i++) applyStimulus(1, 0, rbit(), opc, P_MEM_RD, 0);
      applyStimulus(1, 1, rbit(), opc, P_MEM_RD, 0);
      applyStimulus(1, rbit(), rbit(), opc, P_WB_MEM, 0);
    end else if (opc == OPC_ST) begin
      applyStimulus(1, rbit(), rbit(), opc, P_ADDR, 0);
      for (int i = 0; i < mw; i++) begin
        if (i == rstAt) begin
          applyStimulus(0, 0, rbit(), opc, P_MEM_WR, 0);
          return;
        end
        applyStimulus(1, 0, rbit(), opc, P_MEM_WR, 0);
      end
      applyStimulus(1, 1, rbit(), opc, P_MEM_WR, 0);
    end else if (opc == OPC_BR) begin
      applyStimulus(1, rbit(), br, opc, P_BRANCH, 0);
    end
  endtask

  // Compare one cycle of DUT outputs against the popped expectation
  task automatic checkOutput(input exp_t e);
    logic [14:0] act;
    act = {mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal};
    compared++;
    if (act !== e.outs) begin
      mismatched++;
      $display("[TB] FAIL outputs cycle %0d: got %b required %b", cycleNo, act, e.outs);
    end
    if (!e.inReset) begin
      compared++;
      if (state !== e.st) begin
        mismatched++;
        $display("[TB] FAIL state cycle %0d: got %0d required %0d", cycleNo, state, e.st);
      end
      compared++;
      if (instr_count !== e.cnt) begin
        mismatched++;
        $display("[TB] FAIL instr_count cycle %0d: got %0d required %0d", cycleNo, instr_count, e.cnt);
      end
    end
  endtask

  // Monitor: pop and check one expectation per cycle, away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput(e);
        cycleNo++;
      end
    end
  end

  // Driver: reset, directed instruction mix, then randomized traffic
  initial begin
    logic [6:0] opc;
    int kind;
    applyStimulus(0, 0, 0, 7'd0, P_FETCH, 0);
    applyStimulus(0, 0, 0, 7'd0, P_FETCH, 0);
    runInstr(OPC_R, 0, 0, 0, -1);
    runInstr(OPC_LD, 0, 3, 0, -1);
    runInstr(OPC_ST, 0, 0, 0, -1);
    runInstr(OPC_BR, 0, 0, 1, -1);
    runInstr(OPC_BR, 0, 0, 0, -1);
    runInstr(7'b1111111, 0, 0, 0, -1);
    runInstr(OPC_I, 2, 0, 0, -1);
    runInstr(OPC_ST, 1, 3, 0, 1);
    runInstr(OPC_R, 0, 0, 0, -1);
    repeat (200) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0: opc = OPC_R;
        1: opc = OPC_I;
        2: opc = OPC_LD;
        3: opc = OPC_ST;
        4: opc = OPC_BR;
        default: begin
          opc = 7'(($urandom));
          while (isLegal(opc)) opc = 7'(($urandom));
        end
      endcase
      runInstr(opc,
               ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
               ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
               rbit(),
               ($urandom_range(0, 9) == 0) ? 0 : -1);
    end
    repeat (3) @(posedge clk);
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard drain: got %0d pending required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
